sc_alu_issue: RTL and testbench

//  Issue sequencer that drives sc_alu. Accepts one decoded-register RV32I OP/OP-IMM

---
 rtl/sc_alu_issue.sv | 215 +++++++++++++++++++++
 tb/tb_sc_alu_issue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_alu_issue.sv
// sc_alu_issue: RV32I OP/OP-IMM issue sequencer for sc_alu.
// Decodes, waits out the ALU latency, presents a valid/ready writeback.
module sc_alu_issue #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [31:0]          issue_instr,
  input  logic [WORD_SIZE-1:0] issue_rs1_val,
  input  logic [WORD_SIZE-1:0] issue_rs2_val,
  output logic [2:0]           alu_op_out,
  output logic [WORD_SIZE-1:0] alu_a_out,
  output logic [WORD_SIZE-1:0] alu_b_out,
  input  logic [WORD_SIZE-1:0] alu_result_in,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [4:0]           wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 wb_illegal
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  localparam int PADW = WORD_SIZE - 5;
  localparam int IMMW = WORD_SIZE - 12;

  typedef enum logic [1:0] {
    IDLE, EXEC, CAPT, WB
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WORD_SIZE-1:0] a_q, a_d;
  logic [WORD_SIZE-1:0] b_q, b_d;
  logic [4:0]           rd_q, rd_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 ill_q, ill_d;

  logic [6:0]           opc;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [WORD_SIZE-1:0] imm;
  logic [WORD_SIZE-1:0] shi;
  logic [WORD_SIZE-1:0] shr;
  logic                 dec_ok;
  logic [2:0]           dec_op;
  logic [WORD_SIZE-1:0] dec_a;
  logic [WORD_SIZE-1:0] dec_b;

  assign opc = issue_instr[6:0];
  assign f3  = issue_instr[14:12];
  assign f7  = issue_instr[31:25];
  assign imm = {{IMMW{issue_instr[31]}},
                issue_instr[31:20]};
  assign shi = {{PADW{1'b0}}, issue_instr[24:20]};
  assign shr = {{PADW{1'b0}}, issue_rs2_val[4:0]};

  // Instruction decode into ALU op and operands.
  always_comb begin
    dec_ok = 1'b0;
    dec_op = ALU_ADD;
    dec_a  = issue_rs1_val;
    dec_b  = issue_rs2_val;
    unique case (1'b1)
      opc == 7'b0010011: begin
        dec_b = imm;
        unique case (f3)
          3'b000: begin
            dec_ok = 1'b1;
            dec_op = ALU_ADD;
          end
          3'b100: begin
            dec_ok = 1'b1;
            dec_op = ALU_XOR;
          end
          3'b110: begin
            dec_ok = 1'b1;
            dec_op = ALU_OR;
          end
          3'b111: begin
            dec_ok = 1'b1;
            dec_op = ALU_AND;
          end
          3'b001: begin
            dec_b  = shi;
            dec_op = ALU_SLL;
            dec_ok = (f7 == 7'b0000000);
          end
          3'b101: begin
            dec_b  = shi;
            dec_op = f7[5] ? ALU_SRA : ALU_SRL;
            dec_ok = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000);
          end
          default: dec_ok = 1'b0;
        endcase
      end
      opc == 7'b0110011: begin
        if (f7 == 7'b0000000) begin
          dec_ok = 1'b1;
          unique case (f3)
            3'b000: dec_op = ALU_ADD;
            3'b001: begin
              dec_op = ALU_SLL;
              dec_b  = shr;
            end
            3'b100: dec_op = ALU_XOR;
            3'b101: begin
              dec_op = ALU_SRL;
              dec_b  = shr;
            end
            3'b110: dec_op = ALU_OR;
            3'b111: dec_op = ALU_AND;
            default: dec_ok = 1'b0;
          endcase
        end else if (f7 == 7'b0100000) begin
          unique case (f3)
            3'b000: begin
              // sc_alu computes B-A, so swap
              dec_ok = 1'b1;
              dec_op = ALU_SUB;
              dec_a  = issue_rs2_val;
              dec_b  = issue_rs1_val;
            end
            3'b101: begin
              dec_ok = 1'b1;
              dec_op = ALU_SRA;
              dec_b  = shr;
            end
            default: dec_ok = 1'b0;
          endcase
        end
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    data_d  = data_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (issue_valid) begin
          rd_d = issue_instr[11:7];
          if (dec_ok) begin
            op_d    = dec_op;
            a_d     = dec_a;
            b_d     = dec_b;
            state_d = EXEC;
          end else begin
            data_d  = '0;
            ill_d   = 1'b1;
            state_d = WB;
          end
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        data_d  = alu_result_in;
        ill_d   = 1'b0;
        state_d = WB;
      end
      WB: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
    end
  end

  assign issue_ready = (state_q == IDLE);
  assign wb_valid    = (state_q == WB);
  assign alu_op_out  = op_q;
  assign alu_a_out   = a_q;
  assign alu_b_out   = b_q;
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;
  assign wb_illegal  = ill_q;

endmodule

// File: tb/tb_sc_alu_issue.sv
// tb_sc_alu_issue: directed + random checks of sc_alu_issue
// against an RV32I semantic model and a sc_alu model.
module tb_sc_alu_issue;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] SLL = 3'd5;
  localparam logic [2:0] SRL = 3'd6;
  localparam logic [2:0] SRA = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [31:0] issue_instr = '0;
  logic [31:0] issue_rs1_val = '0;
  logic [31:0] issue_rs2_val = '0;
  logic [2:0]  alu_op_out;
  logic [31:0] alu_a_out;
  logic [31:0] alu_b_out;
  logic [31:0] alu_res = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_illegal;

  int nvec = 0;
  int nerr = 0;

  logic [2:0]  m_op = ADD;
  logic [31:0] m_a  = '0;
  logic [31:0] m_b  = '0;

  always #5 clk = ~clk;

  sc_alu_issue #(.WORD_SIZE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_instr  (issue_instr),
    .issue_rs1_val(issue_rs1_val),
    .issue_rs2_val(issue_rs2_val),
    .alu_op_out   (alu_op_out),
    .alu_a_out    (alu_a_out),
    .alu_b_out    (alu_b_out),
    .alu_result_in(alu_res),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_illegal   (wb_illegal)
  );

  function automatic logic [31:0] alu_fn(
    input logic [2:0] op,
    input logic [31:0] a, b);
    case (op)
      ADD:     return a + b;
      SUB:     return b - a;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SLL:     return a << b[4:0];
      SRL:     return a >> b[4:0];
      default: return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  always_ff @(posedge clk)
    alu_res <= alu_fn(alu_op_out, alu_a_out, alu_b_out);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_i(
    input logic [11:0] imm, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] opc);
    return {imm, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] mk_r(
    input logic [6:0] f7, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  // RV32I meaning of the instruction plus expected ALU drive.
  task automatic ref_dec(
    input logic [31:0] i, r1, r2,
    output bit ill, output logic [31:0] res,
    output logic [2:0] op,
    output logic [31:0] a, b);
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [6:0]  f7;
    logic [2:0]  f3;
    imm = {{20{i[31]}}, i[31:20]};
    sh  = i[24:20];
    f7  = i[31:25];
    f3  = i[14:12];
    ill = 1'b0;
    op  = ADD;
    a   = r1;
    b   = r2;
    res = '0;
    if (i[6:0] == 7'h13) begin
      b = imm;
      case (f3)
        3'd0: res = r1 + imm;
        3'd4: begin op = XOR; res = r1 ^ imm; end
        3'd6: begin op = OR;  res = r1 | imm; end
        3'd7: begin op = AND; res = r1 & imm; end
        3'd1: begin
          op = SLL; b = {27'd0, sh};
          res = r1 << sh;
          ill = (f7 != 7'h00);
        end
        3'd5: begin
          b = {27'd0, sh};
          if (f7 == 7'h00) begin
            op = SRL; res = r1 >> sh;
          end else if (f7 == 7'h20) begin
            op = SRA;
            res = 32'($signed(r1) >>> sh);
          end else ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end else if (i[6:0] == 7'h33) begin
      sh = r2[4:0];
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: res = r1 + r2;
          3'd1: begin
            op = SLL; b = {27'd0, sh};
            res = r1 << sh;
          end
          3'd4: begin op = XOR; res = r1 ^ r2; end
          3'd5: begin
            op = SRL; b = {27'd0, sh};
            res = r1 >> sh;
          end
          3'd6: begin op = OR;  res = r1 | r2; end
          3'd7: begin op = AND; res = r1 & r2; end
          default: ill = 1'b1;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        op = SUB; a = r2; b = r1;
        res = r1 - r2;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        op = SRA; b = {27'd0, sh};
        res = 32'($signed(r1) >>> sh);
      end else ill = 1'b1;
    end else ill = 1'b1;
    if (ill) res = '0;
  endtask

  task automatic chk_rst();
    chk("rst_ready", issue_ready, 1);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_ill", wb_illegal, 0);
    chk("rst_op", alu_op_out, ADD);
    chk("rst_a", alu_a_out, 0);
    chk("rst_b", alu_b_out, 0);
  endtask

  task automatic chk_alu(input string tag);
    chk({tag, "_op"}, alu_op_out, m_op);
    chk({tag, "_a"}, alu_a_out, m_a);
    chk({tag, "_b"}, alu_b_out, m_b);
  endtask

  // One full transaction; called right after a posedge (+1).
  task automatic run(input logic [31:0] ins, r1, r2,
                     input int dly);
    bit          ill;
    logic [31:0] res, ea, eb;
    logic [2:0]  eop;
    int          k;
    ref_dec(ins, r1, r2, ill, res, eop, ea, eb);
    chk("ready_idle", issue_ready, 1);
    issue_instr   = ins;
    issue_rs1_val = r1;
    issue_rs2_val = r2;
    issue_valid   = 1'b1;
    @(posedge clk);
    #1;
    issue_valid   = 1'b0;
    issue_rs1_val = $urandom;
    issue_rs2_val = $urandom;
    issue_instr   = $urandom;
    if (!ill) begin
      m_op = eop; m_a = ea; m_b = eb;
    end
    chk_alu("alu_acc");
    k = 1;
    while (!wb_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", k, ill ? 1 : 3);
    for (int j = 0; j < dly; j++) begin
      @(posedge clk);
      #1;
      chk("hold_wbv", wb_valid, 1);
      chk("hold_data", wb_data, res);
      chk("hold_rdy", issue_ready, 0);
    end
    chk("wb_rd", wb_rd, ins[11:7]);
    chk("wb_data", wb_data, res);
    chk("wb_ill", wb_illegal, ill);
    chk_alu("alu_wb");
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    chk("post_wbv", wb_valid, 0);
  endtask

  initial begin
    logic [31:0] ins, r1, r2;
    int          s;
    logic [6:0]  f7;
    #2;
    chk_rst();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(mk_i(12'hfff, 3'd0, 5'd5, 7'h13), 5, 0, 0);
    run(mk_r(7'h20, 3'd0, 5'd9), 10, 3, 0);
    run(mk_r(7'h00, 3'd1, 5'd7), 1, 32'h21, 1);
    run(mk_i({7'h20, 5'd4}, 3'd5, 5'd3, 7'h13),
        32'h8000_0000, 0, 0);
    run(mk_i(12'h005, 3'd2, 5'd4, 7'h13), 9, 0, 0);
    run(mk_i(12'h005, 3'd0, 5'd6, 7'h03), 9, 0, 0);
    run(mk_r(7'h00, 3'd4, 5'd0), 32'hf0f0, 32'h0ff0, 5);

    // issue_valid held high: only the edge after the handshake accepts
    issue_instr   = mk_r(7'h00, 3'd0, 5'd8);
    issue_rs1_val = 1;
    issue_rs2_val = 2;
    issue_valid   = 1'b1;
    @(posedge clk);
    #1;
    m_op = ADD; m_a = 1; m_b = 2;
    chk("b2b_busy", issue_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_wbv", wb_valid, 1);
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    chk("b2b_idle", issue_ready, 1);
    chk("b2b_wbv0", wb_valid, 0);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    chk("b2b_acc", issue_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_wbv2", wb_valid, 1);
    chk("b2b_data", wb_data, 3);
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;

    // reset while in EXEC
    issue_instr   = mk_r(7'h00, 3'd0, 5'd11);
    issue_rs1_val = 7;
    issue_rs2_val = 8;
    issue_valid   = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_op = ADD; m_a = 0; m_b = 0;
    chk_rst();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(mk_r(7'h00, 3'd0, 5'd11), 7, 8, 0);

    for (int n = 0; n < 150; n++) begin
      s  = $urandom_range(0, 9);
      f7 = 7'h00;
      case ($urandom_range(0, 5))
        3, 4:    f7 = 7'h20;
        5:       f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      ins = $urandom;
      ins[31:25] = f7;
      if (s < 5)      ins[6:0] = 7'h13;
      else if (s < 9) ins[6:0] = 7'h33;
      r1 = $urandom;
      r2 = $urandom;
      run(ins, r1, r2, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
